// File: rtl/word_serializer.sv
// word_serializer: LSB-first parallel-to-serial transmitter with a valid/ready intake and an idle gap between frames.
// Optional macro WORD_SERIALIZER_PARITY_EN appends one even-parity bit (XOR of the data bits) to every frame.
// Ports:
//   i_clk    clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_word   parallel word, sampled only on the handshake
//   i_valid  word-available request
//   o_ready  block accepts a word on this edge
//   o_dout   serial data, LSB first, 0 outside a frame
//   o_frame  high while o_dout carries a frame bit
//   o_done   one-cycle pulse on the last frame bit
//   o_busy   high while shifting or in the inter-frame gap
module word_serializer #(
  parameter int LENGTH     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [LENGTH-1:0] i_word,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_frame,
  output logic              o_done,
  output logic              o_busy
);
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FLEN = LENGTH + 1;
  logic [FLEN-1:0] word_ext;
  assign word_ext = {^i_word, i_word};
`else
  localparam int FLEN = LENGTH;
  logic [FLEN-1:0] word_ext;
  assign word_ext = i_word;
`endif
  localparam int CW = $clog2(LENGTH + 1);
  // gap counter only has to reach GAP_CYCLES-1
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t          state_q;
  logic [FLEN-1:0] sh_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic            ready_q, dout_q, frame_q, done_q, busy_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      dout_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && i_valid) begin
            // bit 0 goes straight to the output register; the rest waits in sh_q
            state_q <= SHIFT;
            sh_q    <= word_ext >> 1;
            cnt_q   <= '0;
            dout_q  <= word_ext[0];
            frame_q <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt_q == CW'(FLEN - 1)) begin
            dout_q  <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            gap_q   <= '0;
            if (GAP_CYCLES > 0) state_q <= GAP;
            else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end else begin
            dout_q <= sh_q[0];
            sh_q   <= sh_q >> 1;
            cnt_q  <= cnt_q + CW'(1);
            done_q <= cnt_q == CW'(FLEN - 2);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else gap_q <= gap_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign o_ready = ready_q;
  assign o_dout  = dout_q;
  assign o_frame = frame_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed plus randomized checks of word_serializer against a bit-list model of each frame.
module tb_word_serializer;
  localparam int L = 32;
  localparam int G = 1;
`ifdef WORD_SERIALIZER_PARITY_EN
  localparam int FL = L + 1;
`else
  localparam int FL = L;
`endif
  logic clk, rst_n, i_valid;
  logic [L-1:0] i_word;
  logic o_ready, o_dout, o_frame, o_done, o_busy;
  int checks = 0, failures = 0;
  word_serializer #(.LENGTH(L), .GAP_CYCLES(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(i_word), .i_valid(i_valid),
    .o_ready(o_ready), .o_dout(o_dout), .o_frame(o_frame), .o_done(o_done), .o_busy(o_busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // frame expected on the wire: data bits LSB first, then parity if enabled
  function automatic logic [FL-1:0] frame_bits(input logic [L-1:0] w);
`ifdef WORD_SERIALIZER_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction
  task automatic chk_idle_outs(input string tag, input logic rdy, input logic bsy);
    chk({tag, "_ready"}, o_ready, rdy);
    chk({tag, "_dout"}, o_dout, 1'b0);
    chk({tag, "_frame"}, o_frame, 1'b0);
    chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_busy"}, o_busy, bsy);
  endtask
  // Present w and wait (bounded) for the handshake edge; afterwards either keep
  // i_valid high with the next word or drop it and scribble on i_word.
  task automatic send(input logic [L-1:0] w, input bit hold, input logic [L-1:0] nw, output int waited);
    i_word = w;
    i_valid = 1'b1;
    waited = 0;
    while (!o_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_timeout", o_ready, 1'b1);
    @(negedge clk);
    i_valid = hold;
    i_word = hold ? nw : $urandom();
  endtask
  // Called on the negedge that should show bit 0; checks the whole frame, the gap
  // and the first IDLE cycle. inj>=0 pulses i_valid with all-ones during bit inj.
  task automatic rx_frame(input logic [L-1:0] w, input int inj);
    logic [FL-1:0] e;
    e = frame_bits(w);
    for (int k = 0; k < FL; k++) begin
      chk("frame", o_frame, 1'b1);
      chk("dout", o_dout, e[k]);
      chk("done", o_done, k == FL - 1);
      chk("busy", o_busy, 1'b1);
      chk("ready_shift", o_ready, 1'b0);
      if (inj >= 0 && k == inj) begin
        i_valid = 1'b1;
        i_word = '1;
      end else if (inj >= 0 && k == inj + 1) i_valid = 1'b0;
      @(negedge clk);
    end
    for (int g = 0; g < G; g++) begin
      chk_idle_outs("gap", 1'b0, 1'b1);
      @(negedge clk);
    end
    chk_idle_outs("idle", 1'b1, 1'b0);
  endtask
  initial begin
    int wt;
    logic [L-1:0] w, w2;
    logic [FL-1:0] e;
    rst_n = 1'b0;
    i_valid = 1'b1;
    i_word = 32'hA5A5_0F0F;
    repeat (3) begin
      @(negedge clk);
      chk_idle_outs("rst", 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("post_rst", 1'b1, 1'b0);
    @(negedge clk);
    i_valid = 1'b0;
    i_word = $urandom();
    rx_frame(32'hA5A5_0F0F, -1);
    send(32'h0000_0001, 1'b1, 32'h8000_0000, wt);
    rx_frame(32'h0000_0001, -1);
    send(32'h8000_0000, 1'b0, '0, wt);
    chk("b2b_first_idle_accept", wt, 0);
    rx_frame(32'h8000_0000, -1);
    @(negedge clk);
    chk_idle_outs("b2b_once", 1'b1, 1'b0);
    send(32'h0, 1'b0, '0, wt);
    rx_frame(32'h0, 5);
    @(negedge clk);
    chk_idle_outs("ignore_not_consumed", 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 1'b0, '0, wt);
    e = frame_bits(32'hDEAD_BEEF);
    for (int k = 0; k < 10; k++) begin
      chk("mid_dout", o_dout, e[k]);
      @(negedge clk);
    end
    chk("mid_bit10", o_dout, e[10]);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outs("async_rst", 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk_idle_outs("rst_hold", 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outs("post_abort", 1'b1, 1'b0);
    w = $urandom();
    send(w, 1'b0, '0, wt);
    rx_frame(w, -1);
`ifdef WORD_SERIALIZER_PARITY_EN
    send(32'h0000_0001, 1'b0, '0, wt);
    rx_frame(32'h0000_0001, -1);
    send(32'h0000_0003, 1'b0, '0, wt);
    rx_frame(32'h0000_0003, -1);
`endif
    for (int i = 0; i < 20; i++) begin
      w = $urandom();
      repeat ($urandom_range(0, 2)) begin
        chk_idle_outs("rand_idle", 1'b1, 1'b0);
        @(negedge clk);
      end
      if ($urandom_range(0, 1) == 1) begin
        w2 = $urandom();
        send(w, 1'b1, w2, wt);
        rx_frame(w, -1);
        send(w2, 1'b0, '0, wt);
        chk("rand_b2b_accept", wt, 0);
        rx_frame(w2, -1);
      end else begin
        send(w, 1'b0, '0, wt);
        rx_frame(w, -1);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
